instr_reg_arbiter: RTL
======================

INSTR_REG_ARBITER -- requirements
Module: instr_reg_arbiter

Interface
REQ-001 Parameter: DEPTH, 32, number of instruction register entries (power of two; matches address_t).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid, req1_valid  input  1 each  write requester N presents an instruction.
REQ-005 req0_ready, req1_ready  output  1 each  requester N instruction accepted this cycle.
REQ-006 req0_opcode, req1_opcode  input  opcode_t (4)  requested opcode.
REQ-007 req0_op_a, req0_op_b, req1_op_a, req1_op_b  input  operand_t (32, signed)  requested operands.
REQ-008 flush  input  1  synchronous discard of all stored entries.
REQ-009 load_en  output  1  write strobe to the instruction register.
REQ-010 write_pointer, read_pointer  output  address_t (5)  register write and read addresses.
REQ-011 opcode, operand_a, operand_b  output  opcode_t / operand_t  write data to the instruction register.
REQ-012 instruction_word  input  instruction_t  combinational read data from the register at read_pointer.
REQ-013 rd_valid  output  1  oldest committed entry available; rd_ready input 1  consumer pops it.
REQ-014 rd_data  output  instruction_t  equals instruction_word.
REQ-015 count  output  6  allocated entries (0..32); full, empty  output  1  count==32, count==0.

Function
REQ-016 The block SHALL operate the register as a circular FIFO: tail (write_pointer), head (read_pointer), both wrapping 31->0.
REQ-017 Arbitration: round-robin between req0 and req1; the requester not granted last wins a tie; after reset req0 has priority.
REQ-018 reqN_ready SHALL be combinational: high only when reqN_valid, that requester wins, full==0 and flush==0; at most one ready per cycle.
REQ-019 Acceptance in cycle N SHALL drive load_en=1 with opcode/operand_a/operand_b/write_pointer=tail registered during cycle N+1; load_en=0 when no acceptance.
REQ-020 count SHALL increment at the edge ending an acceptance cycle; tail advances at the edge ending the load_en cycle.
REQ-021 rd_valid SHALL equal (count minus pending-write flag) != 0; an entry accepted in cycle N is readable from cycle N+2.
REQ-022 read_pointer SHALL equal head continuously; pop (rd_valid & rd_ready) advances head by one and decrements count.
REQ-023 Simultaneous accept and pop: count unchanged, both pointers advance.
REQ-024 At full, ready SHALL stay low even if a pop occurs that cycle (no bypass).
REQ-025 rd_ready with rd_valid=0 SHALL be ignored; valid without ready SHALL hold the requester (no drop, no reorder).
REQ-026 flush in cycle N: head, tail, count cleared to 0 at that edge; a write driven in cycle N completes in the register but is discarded; flush overrides pop.
REQ-027 FSM states: IDLE (empty, no pending), FILL (0<count<32), FULL (count==32); transitions follow count after each edge; flush forces IDLE.

Reset
REQ-028 reset_n low SHALL immediately clear: load_en, write_pointer, read_pointer, opcode, operand_a, operand_b, count, rd_valid, reqN_ready = 0; empty=1, full=0; state IDLE; round-robin priority req0.
REQ-029 Reset asserted mid-write SHALL cancel load_en immediately; no entry is counted.

Verification
REQ-030 req0 only, opcode ADD, op_a=5, op_b=3 at cycle 0 -> load_en=1, write_pointer=0 in cycle 1; rd_valid=1 in cycle 2, rd_data.opc=ADD, op_a=5, op_b=3.
REQ-031 req0 and req1 both valid for 4 cycles -> grants alternate 0,1,0,1; write_pointer 0,1,2,3.
REQ-032 32 writes, no pops -> full=1, count=32, ready low; 33rd held; one pop -> 33rd accepted next cycle at write_pointer 0 (wrap).
REQ-033 Accept and pop in the same cycle at count=5 -> count stays 5; head and tail each +1.
REQ-034 flush at count=10 -> next cycle count=0, empty=1, rd_valid=0, pointers 0.
REQ-035 reset_n low during load_en=1 -> load_en drops without a clock edge; after release count=0, req0 wins first tie.

Source files
------------

// File: rtl/instr_reg_arbiter_if.sv
// Bundle between two write requesters, the instruction register and its consumer.
// The arbiter sits on the slave side; requesters, register and consumer form the master side.
interface instr_reg_arbiter_if #(
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic               req0_valid;
    logic               req1_valid;
    logic               req0_ready;
    logic               req1_ready;
    logic [3:0]         req0_opcode;
    logic [3:0]         req1_opcode;
    logic signed [31:0] req0_op_a;
    logic signed [31:0] req0_op_b;
    logic signed [31:0] req1_op_a;
    logic signed [31:0] req1_op_b;
    logic               flush;

    logic               load_en;
    logic [AW-1:0]      write_pointer;
    logic [AW-1:0]      read_pointer;
    logic [3:0]         opcode;
    logic signed [31:0] operand_a;
    logic signed [31:0] operand_b;
    // Instruction word layout: {opcode[3:0], op_a[31:0], op_b[31:0]}
    logic [67:0]        instruction_word;

    logic               rd_valid;
    logic               rd_ready;
    logic [67:0]        rd_data;
    logic [CW-1:0]      count;
    logic               full;
    logic               empty;

    modport slave (
        input  req0_valid, req1_valid,
        input  req0_opcode, req1_opcode,
        input  req0_op_a, req0_op_b, req1_op_a, req1_op_b,
        input  flush, instruction_word, rd_ready,
        output req0_ready, req1_ready,
        output load_en, write_pointer, read_pointer,
        output opcode, operand_a, operand_b,
        output rd_valid, rd_data, count, full, empty
    );

    modport master (
        output req0_valid, req1_valid,
        output req0_opcode, req1_opcode,
        output req0_op_a, req0_op_b, req1_op_a, req1_op_b,
        output flush, instruction_word, rd_ready,
        input  req0_ready, req1_ready,
        input  load_en, write_pointer, read_pointer,
        input  opcode, operand_a, operand_b,
        input  rd_valid, rd_data, count, full, empty
    );
endinterface

// File: rtl/instr_reg_arbiter.sv
// Round-robin arbiter feeding an external instruction register operated as a circular FIFO.
// Writes land one cycle after acceptance; entries become readable once the write has completed.
module instr_reg_arbiter #(
    parameter int DEPTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    instr_reg_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_FULL
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      head_q, head_d;
    logic [AW-1:0]      tail_q, tail_d;
    logic [CW-1:0]      count_q, count_d;
    logic               load_q, load_d;
    logic [3:0]         opc_q, opc_d;
    logic signed [31:0] opa_q, opa_d;
    logic signed [31:0] opb_q, opb_d;
    // prio_q=1 means req1 wins the next tie (req0 was granted last)
    logic               prio_q, prio_d;

    logic win0, win1, grant0, grant1, accept, pop, rd_valid, full;

    assign full     = (state_q == S_FULL);
    assign win0     = bus.req0_valid & (~bus.req1_valid | ~prio_q);
    assign win1     = bus.req1_valid & (~bus.req0_valid |  prio_q);
    assign grant0   = win0 & ~full & ~bus.flush & reset_n;
    assign grant1   = win1 & ~full & ~bus.flush & reset_n;
    assign accept   = grant0 | grant1;
    // The entry whose write is still in flight is counted but not yet readable
    assign rd_valid = (count_q - CW'(load_q)) != '0;
    assign pop      = rd_valid & bus.rd_ready & ~bus.flush;

    assign bus.req0_ready    = grant0;
    assign bus.req1_ready    = grant1;
    assign bus.load_en       = load_q;
    assign bus.write_pointer = tail_q;
    assign bus.read_pointer  = head_q;
    assign bus.opcode        = opc_q;
    assign bus.operand_a     = opa_q;
    assign bus.operand_b     = opb_q;
    assign bus.rd_valid      = rd_valid;
    assign bus.rd_data       = bus.instruction_word;
    assign bus.count         = count_q;
    assign bus.full          = full;
    assign bus.empty         = (state_q == S_IDLE);

    always_comb begin
        load_d  = accept;
        opc_d   = opc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        prio_d  = prio_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CW'(accept) - CW'(pop);
        state_d = state_q;

        if (grant0) begin
            opc_d  = bus.req0_opcode;
            opa_d  = bus.req0_op_a;
            opb_d  = bus.req0_op_b;
            prio_d = 1'b1;
        end else if (grant1) begin
            opc_d  = bus.req1_opcode;
            opa_d  = bus.req1_op_a;
            opb_d  = bus.req1_op_b;
            prio_d = 1'b0;
        end

        if (load_q) tail_d = tail_q + AW'(1);
        if (pop)    head_d = head_q + AW'(1);

        // A write already in flight still reaches the register but is forgotten here
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end

        if (bus.flush || count_d == '0) state_d = S_IDLE;
        else if (count_d == FULL_CNT)   state_d = S_FULL;
        else                            state_d = S_FILL;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            load_q  <= 1'b0;
            opc_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            prio_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            load_q  <= load_d;
            opc_q   <= opc_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            prio_q  <= prio_d;
        end
    end
endmodule
